// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed display scanner: FSM encoding and
// default slot timing.
package disp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam int SLOT_CYC_DEF  = 100000;
    localparam int BLANK_CYC_DEF = 2000;

endpackage

// File: rtl/slot_counter.sv
// Per-digit slot counter with terminal-count flags for the end of the
// blanking interval and the end of the whole slot.
module slot_counter #(
    parameter int SLOT_CYC  = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_blank,
    output logic at_slot
);

    localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_blank = (cnt == BLANK_LAST);
    assign at_slot  = (cnt == SLOT_LAST);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit display scan controller: blanks each slot briefly while the
// external segment mux settles, then latches and shows that digit.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SLOT_CYC  = SLOT_CYC_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] digit_en,
    input  logic [7:0] seg_in,
    output logic [2:0] scan_s,
    output logic [7:0] AN,
    output logic [7:0] SEGMENT,
    output logic       frame_done
);

    logic [1:0] state;
    logic       at_blank;
    logic       at_slot;
    logic       cnt_clr;
    logic       cnt_inc;

    // The counter restarts whenever scanning stops or a slot completes.
    assign cnt_clr = !en || (state == ST_IDLE) || ((state == ST_SHOW) && at_slot);
    assign cnt_inc = (state == ST_BLANK) || (state == ST_SHOW);

    slot_counter #(
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .at_blank (at_blank),
        .at_slot  (at_slot)
    );

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state      <= ST_IDLE;
            scan_s     <= 3'd0;
            AN         <= 8'hFF;
            SEGMENT    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_BLANK;
                end
                ST_BLANK: begin
                    // Mux output has settled; latch this digit for the rest of the slot.
                    if (at_blank) begin
                        state   <= ST_SHOW;
                        SEGMENT <= seg_in;
                        AN      <= ~(8'b1 << scan_s) | ~digit_en;
                    end
                end
                ST_SHOW: begin
                    if (at_slot) begin
                        state      <= ST_BLANK;
                        scan_s     <= scan_s + 3'd1;
                        AN         <= 8'hFF;
                        SEGMENT    <= 8'hFF;
                        frame_done <= (scan_s == 3'd7);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter SLOT_CYC, default 100000, clock cycles per digit slot (1 ms at 100 MHz).
REQ-002 Parameter BLANK_CYC, default 2000, leading cycles of each slot with all digits off.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  scan enable; 0 forces display dark and scanning stopped.
REQ-006 digit_en  input  8  per-digit enable mask, bit i = digit i.
REQ-007 seg_in  input  8  active-low segment code of the currently selected digit, from the 8-bit 8:1 segment mux.
REQ-008 scan_s  output  3  digit select driven to the segment mux select input.
REQ-009 AN  output  8  active-low digit anode enables.
REQ-010 SEGMENT  output  8  active-low segment outputs, {dp,g,f,e,d,c,b,a}.
REQ-011 frame_done  output  1  one-cycle pulse at the end of digit 7's slot.

Function
REQ-012 Legal parameters are 1 <= BLANK_CYC < SLOT_CYC; any other value is a configuration error and the block need not operate.
REQ-013 The FSM has three states: IDLE, BLANK, SHOW; one slot counter, cnt, is wide enough for SLOT_CYC-1.
REQ-014 IDLE: AN=8'hFF, SEGMENT=8'hFF, cnt=0, scan_s=0; en=1 moves to BLANK on the next edge.
REQ-015 BLANK: AN=8'hFF, SEGMENT=8'hFF, cnt increments; at cnt==BLANK_CYC-1, next state is SHOW.
REQ-016 BLANK->SHOW edge: SEGMENT <= seg_in; AN <= ~(8'b1<<scan_s) | ~digit_en.
REQ-017 seg_in is sampled once per slot, on the BLANK->SHOW edge only; later seg_in changes are ignored until the next slot.
REQ-018 SHOW: AN and SEGMENT are held, cnt increments; at cnt==SLOT_CYC-1, cnt <= 0, scan_s <= scan_s+1 (7 wraps to 0), AN <= 8'hFF, SEGMENT <= 8'hFF, next state is BLANK.
REQ-019 scan_s changes only on the SHOW->BLANK edge, so the mux output has BLANK_CYC cycles to settle before it is sampled.
REQ-020 frame_done = 1 for exactly the cycle after the SHOW->BLANK edge that follows digit 7's slot; otherwise frame_done = 0.
REQ-021 A digit with digit_en=0 still consumes its full slot with its anode off; the refresh period is always 8*SLOT_CYC.
REQ-022 digit_en is sampled with seg_in on the BLANK->SHOW edge; changes during SHOW take effect next slot.
REQ-023 At most one AN bit is 0 in any cycle.
REQ-024 en=0 in any state: the next edge enters IDLE, AN=8'hFF, SEGMENT=8'hFF, scan_s=0, cnt=0, no frame_done; en=0 on the frame-end edge suppresses that pulse.
REQ-025 en re-asserted restarts at digit 0, BLANK, cnt=0.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE, cnt=0, scan_s=3'd0, AN=8'hFF, SEGMENT=8'hFF, frame_done=0; rst has priority over en.
REQ-027 Reset mid-slot or mid-frame discards progress; no partial frame_done is produced.

Structure
REQ-028 A shared package disp_pkg holds the state encoding (IDLE/BLANK/SHOW) and the SLOT_CYC/BLANK_CYC defaults.
REQ-029 The slot counter is a sub-module slot_counter (clear, enable, terminal-count compare outputs for BLANK_CYC-1 and SLOT_CYC-1).
REQ-030 All outputs are registered; there is no combinational path from seg_in or digit_en to AN, SEGMENT or scan_s.

Verification (SLOT_CYC=8, BLANK_CYC=2)
REQ-031 rst=1 for 3 cycles, en=1 -> AN=8'hFF, SEGMENT=8'hFF, scan_s=0, frame_done=0 during reset; first SHOW has AN=8'hFE, SEGMENT=seg_in captured 2 cycles after leaving IDLE.
REQ-032 en=1, digit_en=8'hFF, seg_in=8'hC0 when scan_s=0 and 8'hF9 when scan_s=1 -> SEGMENT=8'hC0 with AN=8'hFE for 6 cycles, then 2 dark cycles, then SEGMENT=8'hF9 with AN=8'hFD.
REQ-033 Free run 3 frames -> frame_done pulses every 64 cycles, exactly 1 cycle wide, coincident with scan_s 7->0 wrap.
REQ-034 digit_en=8'hF5 -> AN never drives digits 1 or 3 low; slot timing is unchanged (64-cycle frame).
REQ-035 en dropped during SHOW of digit 5 -> next cycle AN=8'hFF, scan_s=0; re-enable restarts at digit 0 with no frame_done.
REQ-036 seg_in toggled every cycle during SHOW -> SEGMENT stays at the BLANK->SHOW sample; an AN one-hot checker passes throughout.
